fetch_ctrl: RTL and testbench

Fetch controller that sequences the instruction memory (`fetch_imem`) for the RISC-V core. It owns the PC and issues one word-aligned read per cycle to the 1-cycle-latency imem. Fetched words are buffered with their PC in a 2-entry queue and handed to decode over a valid/ready handshake. It also applies branch/jump redirects from execute and raises a sticky fault on misaligned or out-of-range PCs.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 48 ++++
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch controller.
// The queue entry pairs each fetched word with the PC it came from.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the imem, decode-handshake, redirect and fault signals around fetch_ctrl.
// The master side is the fetch controller; the slave side is imem, decode and execute.
interface fetch_ctrl_if;

    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        input  en,
        input  imem_rdata,
        input  inst_ready,
        input  redirect,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        output inst_valid,
        output inst_out,
        output inst_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        output en,
        output imem_rdata,
        output inst_ready,
        output redirect,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        input  inst_valid,
        input  inst_out,
        input  inst_pc,
        input  fault,
        input  fault_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of fetched (pc, inst) entries with push, pop and flush.
// Flush has priority over any push or pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Guarded so a misbehaving caller can never overrun or underrun the storage
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CNT_W'(QUEUE_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues one imem read per cycle, buffers responses
// for decode, applies execute redirects and latches a sticky fault on bad PCs.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

    fetch_state_e     state;
    fetch_state_e     state_nx;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_nx;
    logic [XLEN-1:0]  req_pc;
    logic             inflight;
    logic             issue;
    logic             fault_set;
    logic             fault_r;
    logic [XLEN-1:0]  fault_pc_r;

    logic             redir;
    logic             resp_live;
    logic             q_valid;
    logic             bypass;
    logic             pop_any;
    logic             want_req;
    logic             bad_pc;
    logic [2:0]       occ;

    logic             q_push;
    logic             q_pop;
    fetch_entry_t     q_entry;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_entry (q_entry),
        .pop        (q_pop),
        .flush      (redir),
        .head       (q_head),
        .count      (q_count)
    );

    // A redirect kills the response arriving this cycle, so it is neither shown nor queued
    assign redir     = bus.redirect && (state == RUN);
    assign resp_live = inflight && !redir;
    assign q_valid   = (q_count != '0);
    assign bypass    = !q_valid && resp_live;
    assign pop_any   = bus.inst_valid && bus.inst_ready;
    assign q_pop     = q_valid && bus.inst_ready;
    assign q_push    = resp_live && !(bypass && bus.inst_ready);

    always_comb begin : entry_build
        q_entry      = '0;
        q_entry.pc   = req_pc;
        q_entry.inst = bus.imem_rdata;
    end

    // Entries held after this cycle, before any new request
    assign occ      = 3'(q_count) + 3'(resp_live) - 3'(pop_any);
    assign want_req = bus.en && !redir && (occ < 3'(QUEUE_DEPTH));
    assign bad_pc   = (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);

    always_comb begin : fsm_next
        state_nx  = state;
        pc_nx     = pc;
        issue     = 1'b0;
        fault_set = 1'b0;
        unique case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (redir) begin
                    pc_nx = bus.redirect_pc;
                end else if (want_req) begin
                    if (bad_pc) begin
                        fault_set = 1'b1;
                        state_nx  = FAULT;
                    end else begin
                        issue = 1'b1;
                        pc_nx = pc + XLEN'(4);
                    end
                end
            end
            FAULT: state_nx = FAULT;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            req_pc     <= '0;
            inflight   <= 1'b0;
            fault_r    <= 1'b0;
            fault_pc_r <= '0;
        end else begin
            pc       <= pc_nx;
            inflight <= issue;
            if (issue) begin
                req_pc <= pc;
            end
            if (fault_set) begin
                fault_r    <= 1'b1;
                fault_pc_r <= pc;
            end
        end
    end

    // Head of queue when non-empty, otherwise the live imem response is presented directly
    assign bus.imem_req   = issue;
    assign bus.imem_addr  = {pc[XLEN-1:2], 2'b00};
    assign bus.inst_valid = q_valid || bypass;
    assign bus.inst_out   = q_valid ? q_head.inst : (bypass ? bus.imem_rdata : '0);
    assign bus.inst_pc    = q_valid ? q_head.pc   : (bypass ? req_pc         : '0);
    assign bus.fault      = fault_r;
    assign bus.fault_pc   = fault_pc_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a 4-word imem model and an expected-instruction queue.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    fetch_entry_t exp_q [$];
    logic [31:0]  imem [4];

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? imem[bus.imem_addr[3:2]] : 32'hdead_beef;
    end

    function automatic fetch_entry_t mk(input logic [31:0] pc, input logic [31:0] inst);
        fetch_entry_t r;
        r.pc   = pc;
        r.inst = inst;
        return r;
    endfunction

    // Leaves the bench 1 time unit into cycle 0 (BOOT)
    task automatic apply_reset();
        rst             = 1'b1;
        bus.en          = 1'b1;
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.en          = 1'b1;
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        #1;
        vecs++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL reset_imem_req got=%0b exp=0", bus.imem_req); end
        vecs++; if (bus.imem_addr !== 32'h0) begin errs++; $display("FAIL reset_imem_addr got=%h exp=0", bus.imem_addr); end
        vecs++; if (bus.inst_valid !== 1'b0) begin errs++; $display("FAIL reset_inst_valid got=%0b exp=0", bus.inst_valid); end
        vecs++; if (bus.inst_out !== 32'h0) begin errs++; $display("FAIL reset_inst_out got=%h exp=0", bus.inst_out); end
        vecs++; if (bus.inst_pc !== 32'h0) begin errs++; $display("FAIL reset_inst_pc got=%h exp=0", bus.inst_pc); end
        vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL reset_fault got=%0b exp=0", bus.fault); end
        vecs++; if (bus.fault_pc !== 32'h0) begin errs++; $display("FAIL reset_fault_pc got=%h exp=0", bus.fault_pc); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL boot_no_req got=%0b exp=0", bus.imem_req); end
        @(negedge clk);
        #1;
        vecs++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errs++; $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        fetch_entry_t e;
        apply_reset();
        exp_q.push_back(mk(32'h0, 32'haaaa_aaaa));
        exp_q.push_back(mk(32'h4, 32'hbbbb_bbbb));
        exp_q.push_back(mk(32'h8, 32'hcccc_cccc));
        exp_q.push_back(mk(32'hc, 32'hdddd_dddd));
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            #1;
            vecs++; if (bus.imem_req !== (cyc <= 4) || (cyc <= 4 && bus.imem_addr !== 32'((cyc - 1) * 4))) begin
                errs++; $display("FAIL stream_req cyc=%0d got req=%0b addr=%h", cyc, bus.imem_req, bus.imem_addr);
            end
            vecs++; if (bus.inst_valid !== (cyc >= 2 && cyc <= 5)) begin
                errs++; $display("FAIL stream_valid cyc=%0d got=%0b", cyc, bus.inst_valid);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL stream_extra cyc=%0d got pc=%h inst=%h exp none", cyc, bus.inst_pc, bus.inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_out !== e.inst) begin
                        errs++; $display("FAIL stream_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.inst_pc, bus.inst_out, e.pc, e.inst);
                    end
                end
            end
            vecs++; if (bus.fault !== (cyc >= 6) || (cyc >= 6 && bus.fault_pc !== 32'h10)) begin
                errs++; $display("FAIL stream_fault cyc=%0d got fault=%0b pc=%h exp_pc=10", cyc, bus.fault, bus.fault_pc);
            end
        end
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL stream_missing got left=%0d exp 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        fetch_entry_t e;
        logic [31:0]  exp_addr;
        apply_reset();
        bus.inst_ready = 1'b0;
        exp_q.push_back(mk(32'h0, 32'haaaa_aaaa));
        exp_q.push_back(mk(32'h4, 32'hbbbb_bbbb));
        exp_q.push_back(mk(32'h8, 32'hcccc_cccc));
        exp_q.push_back(mk(32'hc, 32'hdddd_dddd));
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            bus.inst_ready = (cyc >= 6);
            #1;
            case (cyc)
                1:       exp_addr = 32'h0;
                2:       exp_addr = 32'h4;
                6:       exp_addr = 32'h8;
                default: exp_addr = 32'hc;
            endcase
            vecs++; if (bus.imem_req !== (cyc inside {1, 2, 6, 7}) || (bus.imem_req && bus.imem_addr !== exp_addr)) begin
                errs++; $display("FAIL bp_req cyc=%0d got req=%0b addr=%h exp_addr=%h", cyc, bus.imem_req, bus.imem_addr, exp_addr);
            end
            vecs++; if (bus.inst_valid !== (cyc >= 2 && cyc <= 9)) begin
                errs++; $display("FAIL bp_valid cyc=%0d got=%0b", cyc, bus.inst_valid);
            end
            if (cyc == 5) begin
                vecs++; if (bus.inst_pc !== 32'h0 || bus.inst_out !== 32'haaaa_aaaa) begin
                    errs++; $display("FAIL bp_head got pc=%h inst=%h exp pc=0 inst=aaaaaaaa", bus.inst_pc, bus.inst_out);
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL bp_extra cyc=%0d got pc=%h inst=%h exp none", cyc, bus.inst_pc, bus.inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_out !== e.inst) begin
                        errs++; $display("FAIL bp_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.inst_pc, bus.inst_out, e.pc, e.inst);
                    end
                end
            end
        end
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL bp_missing got left=%0d exp 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        fetch_entry_t e;
        logic [31:0]  exp_addr;
        apply_reset();
        exp_q.push_back(mk(32'h0, 32'haaaa_aaaa));
        exp_q.push_back(mk(32'h8, 32'hcccc_cccc));
        exp_q.push_back(mk(32'hc, 32'hdddd_dddd));
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            bus.redirect    = (cyc == 3);
            bus.redirect_pc = 32'h8;
            #1;
            case (cyc)
                1:       exp_addr = 32'h0;
                2:       exp_addr = 32'h4;
                4:       exp_addr = 32'h8;
                default: exp_addr = 32'hc;
            endcase
            vecs++; if (bus.imem_req !== (cyc inside {1, 2, 4, 5}) || (bus.imem_req && bus.imem_addr !== exp_addr)) begin
                errs++; $display("FAIL redir_req cyc=%0d got req=%0b addr=%h exp_addr=%h", cyc, bus.imem_req, bus.imem_addr, exp_addr);
            end
            vecs++; if (bus.inst_valid !== (cyc inside {2, 5, 6})) begin
                errs++; $display("FAIL redir_valid cyc=%0d got=%0b", cyc, bus.inst_valid);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL redir_extra cyc=%0d got pc=%h inst=%h exp none", cyc, bus.inst_pc, bus.inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_out !== e.inst) begin
                        errs++; $display("FAIL redir_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.inst_pc, bus.inst_out, e.pc, e.inst);
                    end
                end
            end
        end
        bus.redirect = 1'b0;
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL redir_missing got left=%0d exp 0", exp_q.size()); end
    endtask

    task automatic test_misaligned();
        fetch_entry_t e;
        apply_reset();
        exp_q.push_back(mk(32'h0, 32'haaaa_aaaa));
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            bus.redirect    = (cyc == 3) || (cyc == 6);
            bus.redirect_pc = (cyc == 3) ? 32'h6 : 32'h0;
            #1;
            vecs++; if (bus.imem_req !== (cyc <= 2)) begin
                errs++; $display("FAIL mis_req cyc=%0d got=%0b addr=%h", cyc, bus.imem_req, bus.imem_addr);
            end
            vecs++; if (bus.inst_valid !== (cyc == 2)) begin
                errs++; $display("FAIL mis_valid cyc=%0d got=%0b", cyc, bus.inst_valid);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL mis_extra cyc=%0d got pc=%h inst=%h exp none", cyc, bus.inst_pc, bus.inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_out !== e.inst) begin
                        errs++; $display("FAIL mis_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.inst_pc, bus.inst_out, e.pc, e.inst);
                    end
                end
            end
            vecs++; if (bus.fault !== (cyc >= 5) || (cyc >= 5 && bus.fault_pc !== 32'h6)) begin
                errs++; $display("FAIL mis_fault cyc=%0d got fault=%0b pc=%h exp_pc=6", cyc, bus.fault, bus.fault_pc);
            end
        end
        bus.redirect = 1'b0;
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL mis_missing got left=%0d exp 0", exp_q.size()); end
        apply_reset();
        vecs++; if (bus.fault !== 1'b0 || bus.fault_pc !== 32'h0) begin
            errs++; $display("FAIL mis_clear got fault=%0b pc=%h exp 0/0", bus.fault, bus.fault_pc);
        end
    endtask

    task automatic test_enable();
        fetch_entry_t e;
        apply_reset();
        exp_q.push_back(mk(32'h0, 32'haaaa_aaaa));
        exp_q.push_back(mk(32'h4, 32'hbbbb_bbbb));
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            bus.en = (cyc == 1) || (cyc == 7);
            #1;
            vecs++; if (bus.imem_req !== (cyc == 1 || cyc == 7) || (bus.imem_req && bus.imem_addr !== ((cyc == 1) ? 32'h0 : 32'h4))) begin
                errs++; $display("FAIL en_req cyc=%0d got req=%0b addr=%h", cyc, bus.imem_req, bus.imem_addr);
            end
            vecs++; if (bus.inst_valid !== (cyc == 2 || cyc == 8)) begin
                errs++; $display("FAIL en_valid cyc=%0d got=%0b", cyc, bus.inst_valid);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL en_extra cyc=%0d got pc=%h inst=%h exp none", cyc, bus.inst_pc, bus.inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_out !== e.inst) begin
                        errs++; $display("FAIL en_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.inst_pc, bus.inst_out, e.pc, e.inst);
                    end
                end
            end
        end
        bus.en = 1'b1;
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL en_missing got left=%0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        fetch_entry_t e;
        apply_reset();
        bus.inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        vecs++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            errs++; $display("FAIL mid_full got valid=%0b pc=%h exp 1/0", bus.inst_valid, bus.inst_pc);
        end
        #2;
        rst = 1'b1;
        #1;
        vecs++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errs++; $display("FAIL mid_req got req=%0b addr=%h exp 0/0", bus.imem_req, bus.imem_addr);
        end
        vecs++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== 32'h0 || bus.inst_pc !== 32'h0) begin
            errs++; $display("FAIL mid_inst got valid=%0b out=%h pc=%h exp 0/0/0", bus.inst_valid, bus.inst_out, bus.inst_pc);
        end
        vecs++; if (bus.fault !== 1'b0 || bus.fault_pc !== 32'h0) begin
            errs++; $display("FAIL mid_fault got fault=%0b pc=%h exp 0/0", bus.fault, bus.fault_pc);
        end
        @(negedge clk);
        rst            = 1'b0;
        bus.inst_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(mk(32'h0, 32'haaaa_aaaa));
        exp_q.push_back(mk(32'h4, 32'hbbbb_bbbb));
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            #1;
            vecs++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'((cyc - 1) * 4)) begin
                errs++; $display("FAIL mid_restart cyc=%0d got req=%0b addr=%h", cyc, bus.imem_req, bus.imem_addr);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL mid_extra cyc=%0d got pc=%h inst=%h exp none", cyc, bus.inst_pc, bus.inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_out !== e.inst) begin
                        errs++; $display("FAIL mid_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.inst_pc, bus.inst_out, e.pc, e.inst);
                    end
                end
            end
        end
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL mid_missing got left=%0d exp 0", exp_q.size()); end
    endtask

    initial begin
        imem[0] = 32'haaaa_aaaa;
        imem[1] = 32'hbbbb_bbbb;
        imem[2] = 32'hcccc_cccc;
        imem[3] = 32'hdddd_dddd;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_enable();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
